// File: rtl/cd_display.sv
// Two-digit multiplexed 7-segment display for the round countdown: 2 clk input-to-segment latency, blinks in WARN, steady "00" in DONE.
// Optional LEAD_ZERO_BLANK_EN blanks a leading tens zero in RUN/WARN.
module cd_display #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000,
  parameter int unsigned WARN_TH   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] cd,
  input  logic       cd_en,
  output logic [7:0] seg,
  output logic [1:0] an
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam logic [4:0]  WARN_V  = 5'(WARN_TH);

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    RUN   = 2'd1,
    WARN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           cd_q;
  logic                 en_q;
  logic [SCAN_W-1:0]    scan_cnt_q;
  logic                 sel_q;
  logic [BLINK_W-1:0]   blink_cnt_q;
  logic                 blink_ph_q;
  logic [7:0]           seg_q, seg_d;
  logic [1:0]           an_q, an_d;
  logic [1:0]           tens;
  logic [3:0]           ones;
  logic [3:0]           dig;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Input never exceeds 31, so three compares give the tens digit directly.
  always_comb begin
    tens = 2'd0;
    ones = cd_q[3:0];
    if (cd_q >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(cd_q - 5'd30);
    end else if (cd_q >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(cd_q - 5'd20);
    end else if (cd_q >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(cd_q - 5'd10);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BLANK: begin
        if (!en_q)                state_d = DONE;
        else if (cd_q <= WARN_V)  state_d = WARN;
        else                      state_d = RUN;
      end
      RUN: begin
        if (!en_q || cd_q == 5'd0) state_d = DONE;
        else if (cd_q <= WARN_V)   state_d = WARN;
      end
      WARN: begin
        if (!en_q || cd_q == 5'd0) state_d = DONE;
        else if (cd_q > WARN_V)    state_d = RUN;
      end
      DONE: begin
        if (en_q && cd_q != 5'd0)
          state_d = (cd_q <= WARN_V) ? WARN : RUN;
      end
    endcase
  end

  always_comb begin
    seg_d = 8'h00;
    an_d  = 2'b00;
    dig   = sel_q ? {2'b00, tens} : ones;
    unique case (state_q)
      BLANK: begin
        seg_d = 8'h00;
        an_d  = 2'b00;
      end
      DONE: begin
        an_d  = sel_q ? 2'b10 : 2'b01;
        seg_d = seg_code(4'd0);
      end
      RUN, WARN: begin
        if (!(state_q == WARN && blink_ph_q)) begin
          an_d  = sel_q ? 2'b10 : 2'b01;
          seg_d = seg_code(dig);
        end
`ifdef LEAD_ZERO_BLANK_EN
        // Slot keeps its time share so the ones digit brightness does not change.
        if (sel_q && tens == 2'd0) begin
          an_d  = 2'b00;
          seg_d = 8'h00;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= BLANK;
      cd_q        <= 5'd0;
      en_q        <= 1'b0;
      scan_cnt_q  <= '0;
      sel_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      seg_q       <= 8'h00;
      an_q        <= 2'b00;
    end else begin
      cd_q    <= cd;
      en_q    <= cd_en;
      state_q <= state_d;
      seg_q   <= seg_d;
      an_q    <= an_d;

      if (state_q != BLANK) begin
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
          scan_cnt_q <= '0;
          sel_q      <= ~sel_q;
        end else begin
          scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
        end
      end

      // Entering or leaving WARN restarts the blink so digits show first.
      if (state_q == WARN && state_d == WARN) begin
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
          blink_cnt_q <= '0;
          blink_ph_q  <= ~blink_ph_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
      end else begin
        blink_cnt_q <= '0;
        blink_ph_q  <= 1'b0;
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: doc/cd_display.md
Name: cd_display

Overview:
- Downstream consumer of the round countdown block. Takes its 5-bit remaining-time value `CD` and its `cd_en` flag, and drives a 2-digit multiplexed 7-segment display.
- Runs on the fast system clock, not the 1 Hz countdown clock. Converts binary to two BCD digits and scans them.
- Blinks the digits during the final seconds. Shows a steady "00" once the round has expired.

Parameters:
- SCAN_DIV, 100000, system clocks per digit slot (100 MHz -> 1 kHz per digit); minimum 2.
- BLINK_DIV, 50000000, system clocks per blink half-period (0.5 s); minimum 2.
- WARN_TH, 5, countdown value at or below which WARN blinking starts; range 1..30.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- cd  input  5  remaining seconds from the countdown block, binary 0..31
- cd_en  input  1  1 = round running, 0 = expired
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-high; dp always 0
- an  output  2  digit enables, active-high; an[0] = ones digit, an[1] = tens digit

Behaviour:
- Reset (rst=0 at a clk edge):
  - seg=8'h00, an=2'b00.
  - State=BLANK; scan_cnt, blink_cnt, sel and blink_phase all 0; capture registers cleared.
- Input capture:
  - cd and cd_en are registered every clk into cd_q and en_q.
  - seg/an are registered outputs, so a change on cd is visible on seg 2 clk later (when that digit is selected).
- BCD conversion (combinational on cd_q):
  - tens = 0..3 via compare against 10/20/30; ones = cd_q - 10*tens.
  - Values 31 display as "31"; no saturation.
- Segment codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps; on wrap, sel toggles.
  - sel=0 drives an=2'b01 with the ones code; sel=1 drives an=2'b10 with the tens code.
  - Scanning runs in all states except BLANK.
- FSM states: BLANK, RUN, WARN, DONE. Transitions are evaluated on en_q/cd_q each clk:
  - BLANK -> DONE if en_q=0; else -> WARN if cd_q<=WARN_TH; else -> RUN. Leaves BLANK after exactly 1 clk.
  - RUN -> DONE if en_q=0 or cd_q=0; -> WARN if cd_q<=WARN_TH.
  - WARN -> DONE if en_q=0 or cd_q=0; -> RUN if cd_q>WARN_TH (reload).
  - DONE -> RUN/WARN when en_q=1 and cd_q!=0, chosen by the WARN_TH comparison (new round).
- Simultaneous events: en_q=0 has priority over every threshold test.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1 only in WARN; on wrap, blink_phase toggles.
  - On entering WARN, blink_cnt=0 and blink_phase=0, so the digits are visible first.
  - In WARN with blink_phase=1: an=2'b00, seg=8'h00. Scan counters keep running.
- DONE: steady "00", no blink; blink_cnt held at 0.
- Reset mid-operation: immediate return to reset values at the next edge, regardless of state.

Optional Feature:
- Macro LEAD_ZERO_BLANK_EN.
- Defined: in RUN and WARN, when tens=0 the tens slot outputs an=2'b00 and seg=8'h00. The slot timing is kept, so the ones digit duty cycle is unchanged. DONE still shows "00".
- Undefined: the tens digit always displays, including a leading 0.

Test Plan (SCAN_DIV=4, BLINK_DIV=8, WARN_TH=5):
- Reset held 3 clk, then release with cd=30, cd_en=1:
  - During reset: seg=00, an=00.
  - Next clk after release: state BLANK.
  - Then RUN, with ones slot an=01 seg=3F and tens slot an=10 seg=4F.
  - sel alternates every 4 clk.
- cd stepped 30->12: seg shows 06 (tens) and 5B (ones) within 2 clk of the relevant slot.
- cd=5, cd_en=1 -> WARN:
  - Digits visible for 8 clk, then an=00 for 8 clk, repeating.
  - cd=6 returns to RUN with steady display.
- cd_en drops 1->0 while cd=3 in WARN: DONE within 2 clk, steady "00" (seg=3F on both slots), no blanking.
- In DONE, cd=30 and cd_en=1 reapplied: RUN, displays "30".
- With LEAD_ZERO_BLANK_EN, cd=7:
  - Tens slot gives an=00 seg=00; ones slot gives an=01 seg=07.
  - Without the macro, the tens slot shows seg=3F.
